// File: rtl/uop_mem_writer_if.sv
// Micro-op handshake bundle between the instruction decoder and the
// micro-op store writer.
//   start   : decoder presents a valid micro-op word
//   ready   : one-cycle acknowledge from the writer
//   data_in : the micro-op word itself
// The master modport is the decoder side and the slave modport is the writer side.
interface uop_mem_writer_if #(
    parameter int width_in = 32
) ();
    logic                start;
    logic                ready;
    logic [width_in-1:0] data_in;

    modport master (output start, output data_in, input ready);
    modport slave  (input start, input data_in, output ready);
endinterface

// File: rtl/uop_mem_writer.sv
// uop_mem_writer: this block sinks the decoder's micro-op stream. Each accepted
// 32-bit word is written big-endian, one byte per cycle, into a byte-wide store
// at an auto-incrementing pointer. The block then acknowledges the word with a
// one-cycle ready pulse. The execute stage reads the store through a
// registered read port.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   up (slave)     : start / ready / data_in handshake
//   clear          : synchronous flush of pointer, word count and overflow (IDLE only)
//   rd_addr/rd_data: read port with one cycle of latency; a read of the
//                    address being written in the same cycle returns the old byte
//   wr_ptr         : bytes stored, which is also the next write address
//   word_count     : number of micro-ops stored
//   full           : fewer than 4 free bytes remain
//   overflow       : sticky flag, set when a word is dropped because the store is full
// width_in must equal 4*byte_w.
//
// state | meaning
// IDLE  | waiting for start; clear is serviced here
// WRITE | four cycles, one byte per cycle, MSB first
// ACK   | ready high for exactly this cycle
// HOLD  | wait for start to drop so a held start is not accepted twice
module uop_mem_writer #(
    parameter int byte_w   = 8,
    parameter int width_in = 32,
    parameter int addr_w   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    uop_mem_writer_if.slave       up,
    input  logic                  clear,
    input  logic [addr_w-1:0]     rd_addr,
    output logic [byte_w-1:0]     rd_data,
    output logic [addr_w:0]       wr_ptr,
    output logic [addr_w-2:0]     word_count,
    output logic                  full,
    output logic                  overflow
);
    localparam int depth = 1 << addr_w;
    localparam logic [addr_w:0] full_lim = (addr_w+1)'(depth - 4);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]          state;
    logic [width_in-1:0] word_q;
    logic [1:0]          bytes_left;
    logic                ack_q;
    logic                wr_en;
    logic [byte_w-1:0]   wr_byte;
    logic [byte_w-1:0]   mem [depth];

    assign up.ready = ack_q;
    assign full     = wr_ptr > full_lim;
    assign wr_en    = (state == WRITE);
    // The latched word is shifted left after each write, so the current byte is always the top byte.
    assign wr_byte  = word_q[width_in-1 -: byte_w];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            word_q     <= '0;
            bytes_left <= '0;
            ack_q      <= 1'b0;
            wr_ptr     <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        wr_ptr     <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end else if (up.start) begin
                        if (full) begin
                            // The word is dropped, but the decoder still receives an acknowledge.
                            overflow <= 1'b1;
                            ack_q    <= 1'b1;
                            state    <= ACK;
                        end else begin
                            word_q     <= up.data_in;
                            bytes_left <= 2'd3;
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    word_q <= word_q << byte_w;
                    if (bytes_left == 2'd0) begin
                        word_count <= word_count + 1'b1;
                        ack_q      <= 1'b1;
                        state      <= ACK;
                    end else begin
                        bytes_left <= bytes_left - 1'b1;
                    end
                end
                ACK: state <= HOLD;
                HOLD: begin
                    if (!up.start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The store contents are not reset; only the pointer and counters are.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[addr_w-1:0]] <= wr_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end
endmodule

// File: tb/tb_uop_mem_writer.sv
module tb_uop_mem_writer;
    localparam int BW    = 8;
    localparam int WI    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_data;
    logic [AW:0]   wr_ptr;
    logic [AW-2:0] word_count;
    logic          full;
    logic          overflow;

    uop_mem_writer_if #(.width_in(WI)) up ();

    uop_mem_writer #(.byte_w(BW), .width_in(WI), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .up(up), .clear(clear),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_ptr(wr_ptr),
        .word_count(word_count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int ptr; int cnt; bit ov; } ack_t;
    typedef struct { int cyc; logic [7:0] val; } rd_t;
    ack_t aq[$];
    rd_t  rq[$];

    // Reference model of the store: a byte array with valid flags, a pointer, a word count and an overflow flag.
    logic [7:0] m_mem [DEPTH];
    bit         m_val [DEPTH];
    int         m_ptr, m_cnt;
    bit         m_ov;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected acknowledges and read-data values and compares them when the DUT presents them.
    always @(negedge clk) begin
        ack_t e;
        if (reset) begin
            if (up.ready) begin
                if (aq.size() == 0) chk("unexpected_ready", 1, 0);
                else begin
                    e = aq.pop_front();
                    chk("ready_cycle", cyc, e.cyc);
                    chk("ack_wr_ptr", int'(wr_ptr), e.ptr);
                    chk("ack_word_count", int'(word_count), e.cnt);
                    chk("ack_overflow", int'(overflow), int'(e.ov));
                    chk("ack_full", int'(full), int'(e.ptr > DEPTH - 4));
                end
            end else if (aq.size() > 0 && cyc > aq[0].cyc) begin
                chk("missing_ready", cyc, aq[0].cyc);
                aq.delete(0);
            end
            while (rq.size() > 0 && rq[0].cyc <= cyc) begin
                chk("rd_data", int'(rd_data), int'(rq[0].val));
                rq.delete(0);
            end
        end
    end

    task automatic issue_word(input logic [31:0] d, input int hold);
        int k, a;
        bit drop;
        @(negedge clk);
        k = cyc;
        drop = (m_ptr > DEPTH - 4);
        up.start = 1'b1;
        up.data_in = d;
        if (drop) begin
            m_ov = 1'b1;
            aq.push_back('{k + 1, m_ptr, m_cnt, m_ov});
        end else begin
            // Watch byte 2 of this word: the old byte before its write edge, and the new byte on the edge after.
            a = m_ptr + 2;
            rd_addr = AW'(a);
            if (m_val[a]) rq.push_back('{k + 4, m_mem[a]});
            rq.push_back('{k + 5, d[15:8]});
            for (int i = 0; i < 4; i++) begin
                m_mem[m_ptr + i] = d[31 - 8*i -: 8];
                m_val[m_ptr + i] = 1'b1;
            end
            m_ptr += 4;
            m_cnt++;
            aq.push_back('{k + 5, m_ptr, m_cnt, m_ov});
        end
        repeat (drop ? 1 : 5) @(negedge clk);
        repeat (hold) @(negedge clk);
        up.start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_ptr = 0; m_cnt = 0; m_ov = 1'b0;
        chk("clear_wr_ptr", int'(wr_ptr), 0);
        chk("clear_word_count", int'(word_count), 0);
        chk("clear_full", int'(full), 0);
        chk("clear_overflow", int'(overflow), 0);
    endtask

    // Assert reset after two bytes of a word have been written.
    task automatic reset_mid_write(input logic [31:0] d);
        @(negedge clk);
        up.start = 1'b1;
        up.data_in = d;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        up.start = 1'b0;
        m_mem[m_ptr] = d[31:24];     m_val[m_ptr] = 1'b1;
        m_mem[m_ptr + 1] = d[23:16]; m_val[m_ptr + 1] = 1'b1;
        m_ptr = 0; m_cnt = 0; m_ov = 1'b0;
        #1;
        chk("midrst_wr_ptr", int'(wr_ptr), 0);
        chk("midrst_ready", int'(up.ready), 0);
        chk("midrst_word_count", int'(word_count), 0);
        chk("midrst_overflow", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        reset = 1'b0; clear = 1'b0; rd_addr = '0;
        up.start = 1'b0; up.data_in = '0;
        m_ptr = 0; m_cnt = 0; m_ov = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(up.ready), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_wr_ptr", int'(wr_ptr), 0);
        chk("rst_word_count", int'(word_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_full", int'(full), 0);
        reset = 1'b1;

        issue_word(32'h9201_04E0, 0);
        issue_word(32'hA1B2_C3D4, 0);
        issue_word(32'h1122_3344, 0);
        issue_word(32'hDEAD_BEEF, 5);   // start held high through ACK and HOLD
        issue_word(32'h5555_AAAA, 0);   // store is full: this word is dropped
        do_clear();
        issue_word(32'h0F0F_F0F0, 0);
        reset_mid_write(32'h7766_5544);
        issue_word(32'hCAFE_F00D, 0);   // lands at mem[0..3]

        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 99));
            if (op < 12) do_clear();
            else if (op < 20 && m_ptr <= DEPTH - 4) reset_mid_write($urandom);
            else issue_word($urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        repeat (5) @(negedge clk);
        chk("ack_queue_drained", aq.size(), 0);
        for (int a = 0; a < DEPTH; a++) begin
            if (m_val[a]) begin
                @(negedge clk);
                rd_addr = AW'(a);
                rq.push_back('{cyc + 1, m_mem[a]});
            end
        end
        repeat (3) @(negedge clk);
        chk("rd_queue_drained", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
